// File: rtl/mass_sort_sequencer_if.sv
// mass_sort_sequencer_if: sensor inputs, classification results, gate drives and tallies of the mass sorting sequencer
interface mass_sort_sequencer_if #(parameter int DATA_W = 10, parameter int CNT_W = 16);
  logic i_enable;
  logic i_fish_present;
  logic i_data_valid;
  logic [DATA_W-1:0] i_data;
  logic o_busy;
  logic o_class_valid;
  logic [1:0] o_class_id;
  logic [DATA_W-1:0] o_mass;
  logic o_gate_1, o_gate_2, o_gate_3;
  logic [CNT_W-1:0] o_cnt_1, o_cnt_2, o_cnt_3, o_cnt_reject, o_cnt_abort;
  modport slave (
    input i_enable, i_fish_present, i_data_valid, i_data,
    output o_busy, o_class_valid, o_class_id, o_mass, o_gate_1, o_gate_2, o_gate_3,
    output o_cnt_1, o_cnt_2, o_cnt_3, o_cnt_reject, o_cnt_abort
  );
  modport master (
    output i_enable, i_fish_present, i_data_valid, i_data,
    input o_busy, o_class_valid, o_class_id, o_mass, o_gate_1, o_gate_2, o_gate_3,
    input o_cnt_1, o_cnt_2, o_cnt_3, o_cnt_reject, o_cnt_abort
  );
endinterface

// File: rtl/mass_sort_sequencer.sv
// mass_sort_sequencer: per-fish settle/average/classify sequencer driving sorting gates and saturating tallies.
// Define MASS_PEAK_MODE_EN to report the peak sample instead of the mean.
module mass_sort_sequencer #(
  parameter int DATA_W   = 10,
  parameter int D1       = 240,
  parameter int D2       = 340,
  parameter int D3       = 400,
  parameter int D4       = 450,
  parameter int SETTLE   = 8,
  parameter int NSAMP    = 16,
  parameter int GATE_CYC = 1000,
  parameter int CNT_W    = 16
) (
  input logic i_clk,
  input logic i_reset,
  mass_sort_sequencer_if.slave bus
);
  localparam int SH = $clog2(NSAMP);
  localparam int AW = DATA_W + SH;
  localparam int SW = $clog2((SETTLE > NSAMP ? SETTLE : NSAMP) + 1);
  localparam int GW = $clog2(GATE_CYC + 1);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACCUM, S_CLASSIFY, S_GATE, S_WAIT_CLR} state_t;
  state_t r_state;
  logic [SW-1:0] r_cnt;
  logic [AW-1:0] r_acc;
  logic [GW-1:0] r_gcnt;
  logic r_busy, r_class_valid, r_gate_1, r_gate_2, r_gate_3;
  logic [1:0] r_class_id;
  logic [DATA_W-1:0] r_mass;
  logic [CNT_W-1:0] r_cnt_1, r_cnt_2, r_cnt_3, r_cnt_reject, r_cnt_abort;
  logic [AW-1:0] w_acc_nxt;
  logic [DATA_W-1:0] w_mass;
  logic [1:0] w_class;
  logic w_last;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
  // The result is resolved from the final sample itself so class_valid lands one cycle after it
  always_comb begin
`ifdef MASS_PEAK_MODE_EN
    w_acc_nxt = (AW'(bus.i_data) > r_acc) ? AW'(bus.i_data) : r_acc;
    w_mass = w_acc_nxt[DATA_W-1:0];
`else
    w_acc_nxt = r_acc + AW'(bus.i_data);
    w_mass = DATA_W'(w_acc_nxt >> SH);
`endif
    w_class = (w_mass >= DATA_W'(D1) && w_mass <= DATA_W'(D2)) ? 2'd1 :
              (w_mass >  DATA_W'(D2) && w_mass <= DATA_W'(D3)) ? 2'd2 :
              (w_mass >  DATA_W'(D3) && w_mass <= DATA_W'(D4)) ? 2'd3 : 2'd0;
    w_last = bus.i_data_valid && r_cnt == SW'(NSAMP - 1);
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_acc <= '0;
      r_gcnt <= '0;
      r_busy <= 1'b0;
      r_class_valid <= 1'b0;
      r_class_id <= '0;
      r_mass <= '0;
      r_gate_1 <= 1'b0;
      r_gate_2 <= 1'b0;
      r_gate_3 <= 1'b0;
      r_cnt_1 <= '0;
      r_cnt_2 <= '0;
      r_cnt_3 <= '0;
      r_cnt_reject <= '0;
      r_cnt_abort <= '0;
    end else begin
      r_class_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_acc <= '0;
          if (bus.i_enable && bus.i_fish_present) begin
            r_state <= S_SETTLE;
            r_busy <= 1'b1;
          end
        end
        S_SETTLE:
          if (!bus.i_fish_present) begin
            r_cnt_abort <= sat(r_cnt_abort);
            r_state <= S_IDLE;
            r_busy <= 1'b0;
          end else if (bus.i_data_valid) begin
            r_cnt <= (r_cnt == SW'(SETTLE - 1)) ? '0 : r_cnt + 1'b1;
            if (r_cnt == SW'(SETTLE - 1)) r_state <= S_ACCUM;
          end
        // The last sample beats a simultaneous fish departure
        S_ACCUM:
          if (w_last) begin
            r_state <= S_CLASSIFY;
            r_class_valid <= 1'b1;
            r_class_id <= w_class;
            r_mass <= w_mass;
            if (w_class == 2'd0) r_cnt_reject <= sat(r_cnt_reject);
            if (w_class == 2'd1) r_cnt_1 <= sat(r_cnt_1);
            if (w_class == 2'd2) r_cnt_2 <= sat(r_cnt_2);
            if (w_class == 2'd3) r_cnt_3 <= sat(r_cnt_3);
          end else if (!bus.i_fish_present) begin
            r_cnt_abort <= sat(r_cnt_abort);
            r_state <= S_IDLE;
            r_busy <= 1'b0;
          end else if (bus.i_data_valid) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
          end
        S_CLASSIFY: begin
          r_gcnt <= '0;
          r_gate_1 <= r_class_id == 2'd1;
          r_gate_2 <= r_class_id == 2'd2;
          r_gate_3 <= r_class_id == 2'd3;
          r_state <= (r_class_id != 2'd0) ? S_GATE : S_WAIT_CLR;
        end
        S_GATE:
          if (r_gcnt == GW'(GATE_CYC - 1)) begin
            r_gate_1 <= 1'b0;
            r_gate_2 <= 1'b0;
            r_gate_3 <= 1'b0;
            r_state <= S_WAIT_CLR;
          end else r_gcnt <= r_gcnt + 1'b1;
        S_WAIT_CLR:
          if (!bus.i_fish_present) begin
            r_state <= S_IDLE;
            r_busy <= 1'b0;
          end
        default: begin
          r_state <= S_IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end
  assign bus.o_busy = r_busy;
  assign bus.o_class_valid = r_class_valid;
  assign bus.o_class_id = r_class_id;
  assign bus.o_mass = r_mass;
  assign bus.o_gate_1 = r_gate_1;
  assign bus.o_gate_2 = r_gate_2;
  assign bus.o_gate_3 = r_gate_3;
  assign bus.o_cnt_1 = r_cnt_1;
  assign bus.o_cnt_2 = r_cnt_2;
  assign bus.o_cnt_3 = r_cnt_3;
  assign bus.o_cnt_reject = r_cnt_reject;
  assign bus.o_cnt_abort = r_cnt_abort;
endmodule

// File: tb/tb_mass_sort_sequencer.sv
// tb_mass_sort_sequencer: directed checks of settle/average, band edges, abort, gating, reset and tally saturation
module tb_mass_sort_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  mass_sort_sequencer_if #(.DATA_W(10), .CNT_W(2)) bus();
  mass_sort_sequencer #(.CNT_W(2)) dut (.i_clk(clk), .i_reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int v);
    bus.i_data_valid = 1'b1;
    bus.i_data = 10'(v);
    tick();
    bus.i_data_valid = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  // 8 heavy junk samples during settling, then 16 samples base+step*i; returns on the class_valid cycle
  task automatic meas(input int base, input int step, input bit drop_last);
    bus.i_fish_present = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send(1023);
    for (int i = 0; i < 15; i++) send(base + step * i);
    if (drop_last) bus.i_fish_present = 1'b0;
    send(base + step * 15);
  endtask
  task automatic gate_len(output int n, output int m);
    n = 0;
    tick();
    m = {bus.o_gate_3, bus.o_gate_2, bus.o_gate_1};
    while ((bus.o_gate_1 | bus.o_gate_2 | bus.o_gate_3) && n < 3000) begin
      n++;
      tick();
    end
  endtask
  task automatic release_fish();
    bus.i_fish_present = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    int n, m;
    int vals[8] = '{240, 340, 341, 400, 401, 450, 451, 239};
    int cls[8] = '{1, 1, 2, 2, 3, 3, 0, 0};
    bus.i_enable = 1'b0;
    bus.i_fish_present = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_data = '0;
    do_reset();
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_cv", bus.o_class_valid, 0);
    chk("rst_id", bus.o_class_id, 0);
    chk("rst_mass", bus.o_mass, 0);
    chk("rst_gates", {bus.o_gate_3, bus.o_gate_2, bus.o_gate_1}, 0);
    chk("rst_cnts", bus.o_cnt_1 + bus.o_cnt_2 + bus.o_cnt_3 + bus.o_cnt_reject + bus.o_cnt_abort, 0);
    bus.i_enable = 1'b1;
    meas(300, 0, 1'b0);
    chk("b1_cv", bus.o_class_valid, 1);
    chk("b1_id", bus.o_class_id, 1);
    chk("b1_mass", bus.o_mass, 300);
    chk("b1_busy", bus.o_busy, 1);
    chk("b1_cnt", bus.o_cnt_1, 1);
    gate_len(n, m);
    chk("b1_cv_off", bus.o_class_valid, 0);
    chk("b1_len", n, 1000);
    chk("b1_mask", m, 1);
    release_fish();
    chk("b1_idle", bus.o_busy, 0);
    do_reset();
    foreach (vals[i]) begin
      meas(vals[i], 0, 1'b0);
      chk($sformatf("band_id_%0d", vals[i]), bus.o_class_id, cls[i]);
      chk($sformatf("band_mass_%0d", vals[i]), bus.o_mass, vals[i]);
      gate_len(n, m);
      chk($sformatf("band_len_%0d", vals[i]), n, cls[i] == 0 ? 0 : 1000);
      chk($sformatf("band_mask_%0d", vals[i]), m, cls[i] == 0 ? 0 : 1 << (cls[i] - 1));
      chk($sformatf("band_busy_%0d", vals[i]), bus.o_busy, 1);
      release_fish();
    end
    chk("band_cnt1", bus.o_cnt_1, 2);
    chk("band_cnt2", bus.o_cnt_2, 2);
    chk("band_cnt3", bus.o_cnt_3, 2);
    chk("band_rej", bus.o_cnt_reject, 2);
    bus.i_fish_present = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send(1023);
    for (int i = 0; i < 5; i++) send(300);
    bus.i_fish_present = 1'b0;
    tick();
    chk("abort_busy", bus.o_busy, 0);
    chk("abort_cv", bus.o_class_valid, 0);
    chk("abort_cnt", bus.o_cnt_abort, 1);
    chk("abort_cnt1", bus.o_cnt_1, 2);
    do_reset();
    meas(300, 0, 1'b0);
    gate_len(n, m);
    for (int i = 0; i < 40; i++) send(300);
    chk("dbl_busy", bus.o_busy, 1);
    chk("dbl_cnt", bus.o_cnt_1, 1);
    release_fish();
    chk("dbl_idle", bus.o_busy, 0);
    meas(300, 0, 1'b0);
    chk("dbl_cv2", bus.o_class_valid, 1);
    chk("dbl_cnt2", bus.o_cnt_1, 2);
    gate_len(n, m);
    release_fish();
    bus.i_fish_present = 1'b1;
    tick();
    bus.i_enable = 1'b0;
    for (int i = 0; i < 8; i++) send(1023);
    for (int i = 0; i < 16; i++) send(420);
    chk("en_off_cv", bus.o_class_valid, 1);
    chk("en_off_id", bus.o_class_id, 3);
    gate_len(n, m);
    release_fish();
    bus.i_fish_present = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("en_off_idle", bus.o_busy, 0);
    release_fish();
    bus.i_enable = 1'b1;
    meas(370, 0, 1'b1);
    chk("last_cv", bus.o_class_valid, 1);
    chk("last_id", bus.o_class_id, 2);
    gate_len(n, m);
    chk("last_len", n, 1000);
    tick();
    chk("last_idle", bus.o_busy, 0);
    meas(370, 0, 1'b0);
    tick();
    for (int i = 0; i < 499; i++) tick();
    chk("rg_pre", bus.o_gate_2, 1);
    reset = 1'b1;
    tick();
    chk("rg_gate", bus.o_gate_2, 0);
    chk("rg_busy", bus.o_busy, 0);
    chk("rg_cnts", bus.o_cnt_1 + bus.o_cnt_2 + bus.o_cnt_3 + bus.o_cnt_reject + bus.o_cnt_abort, 0);
    reset = 1'b0;
    release_fish();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      meas(420, 0, 1'b0);
      gate_len(n, m);
      release_fish();
    end
    chk("sat_cnt3", bus.o_cnt_3, 3);
    meas(100, 1, 1'b0);
`ifdef MASS_PEAK_MODE_EN
    chk("ramp_mass", bus.o_mass, 115);
`else
    chk("ramp_mass", bus.o_mass, 107);
`endif
    chk("ramp_id", bus.o_class_id, 0);
    gate_len(n, m);
    chk("ramp_len", n, 0);
    chk("ramp_rej", bus.o_cnt_reject, 1);
    release_fish();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
